// File: rtl/pc_fetch_ctrl_if.sv
// Bundle of PC-sequencing and instruction-fetch signals between the fetch
// controller (master) and the PC register / instruction memory / pipeline (slave).
interface pc_fetch_ctrl_if #(
    parameter int N = 32
);
    logic [N-1:0] pc_value;
    logic         jump;
    logic [N-1:0] jump_target;
    logic         branch_taken;
    logic [N-1:0] branch_target;
    logic         load_use_hazard;
    logic         trap_req;
    logic         imem_ready;
    logic [N-1:0] next_pc;
    logic         pc_stall;
    logic         flush_if;
    logic         imem_req;
    logic         fetch_fault;
    logic [N-1:0] epc;

    modport master (
        input  pc_value, jump, jump_target, branch_taken, branch_target,
               load_use_hazard, trap_req, imem_ready,
        output next_pc, pc_stall, flush_if, imem_req, fetch_fault, epc
    );

    modport slave (
        output pc_value, jump, jump_target, branch_taken, branch_target,
               load_use_hazard, trap_req, imem_ready,
        input  next_pc, pc_stall, flush_if, imem_req, fetch_fault, epc
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing controller: picks the next PC (trap, jump, branch, pending
// redirect, PC+4), stalls the PC register while instruction memory is busy,
// and raises a fetch-fault trap when a fetch waits too long.
// State changes on the falling clock edge, the same edge as the PC register.
module pc_fetch_ctrl #(
    parameter int           N        = 32,
    parameter logic [N-1:0] TRAP_VEC = 32'h0040_0180,
    parameter int           TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            reset,
    pc_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t       fsm_r;
    logic [7:0]   cnt_r;
    logic         pend_valid_r;
    logic [N-1:0] pend_target_r;
    logic [N-1:0] epc_r;
    logic         fetch_fault_r;

    logic [N-1:0] seq_pc_s;
    logic [N-1:0] sel_pc_s;
    logic         sel_redirect_s;
    logic         redirect_req_s;
    logic [N-1:0] capture_target_s;
    logic         advance_s;
    logic         fault_s;

    // Word-align a redirect target by clearing the byte offset.
    function automatic logic [N-1:0] align_f(input logic [N-1:0] addr);
        return {addr[N-1:2], 2'b00};
    endfunction

    assign seq_pc_s         = bus.pc_value + N'(32'd4);
    assign redirect_req_s   = bus.jump | bus.branch_taken;
    assign capture_target_s = bus.jump ? align_f(bus.jump_target) : align_f(bus.branch_target);
    assign fault_s          = (fsm_r == ST_WAIT) && !bus.imem_ready && (cnt_r == 8'(TIMEOUT - 1));

    // Priority select of the next PC source when the PC may advance.
    always_comb begin
        sel_pc_s       = seq_pc_s;
        sel_redirect_s = 1'b0;
        if (bus.trap_req) begin
            sel_pc_s       = TRAP_VEC;
            sel_redirect_s = 1'b1;
        end else if (bus.jump) begin
            sel_pc_s       = align_f(bus.jump_target);
            sel_redirect_s = 1'b1;
        end else if (bus.branch_taken) begin
            sel_pc_s       = align_f(bus.branch_target);
            sel_redirect_s = 1'b1;
        end else if (pend_valid_r) begin
            sel_pc_s       = pend_target_r;
            sel_redirect_s = 1'b1;
        end else begin
            sel_pc_s       = seq_pc_s;
            sel_redirect_s = 1'b0;
        end
    end

    // A trap always advances; otherwise a returned word advances unless a
    // load-use hazard holds it and no jump/branch overrides the hazard.
    always_comb begin
        advance_s = 1'b0;
        if (bus.trap_req) begin
            advance_s = 1'b1;
        end else if (bus.imem_ready && (!bus.load_use_hazard || redirect_req_s)) begin
            advance_s = 1'b1;
        end else begin
            advance_s = 1'b0;
        end
    end

    // Drive the PC register and fetch handshake from state and live inputs.
    always_comb begin
        bus.next_pc  = bus.pc_value;
        bus.pc_stall = 1'b1;
        bus.flush_if = 1'b0;
        bus.imem_req = 1'b0;
        case (fsm_r)
            ST_BOOT: begin
                if (bus.trap_req) begin
                    bus.next_pc  = TRAP_VEC;
                    bus.pc_stall = 1'b0;
                    bus.flush_if = 1'b1;
                end else begin
                    bus.next_pc  = bus.pc_value;
                end
            end
            ST_FETCH, ST_WAIT: begin
                bus.imem_req = 1'b1;
                if (advance_s) begin
                    bus.next_pc  = sel_pc_s;
                    bus.pc_stall = 1'b0;
                    bus.flush_if = sel_redirect_s;
                end else if (fault_s) begin
                    bus.next_pc  = TRAP_VEC;
                    bus.pc_stall = 1'b0;
                    bus.flush_if = 1'b1;
                end else begin
                    bus.next_pc  = bus.pc_value;
                end
            end
            default: begin
                bus.next_pc = bus.pc_value;
            end
        endcase
    end

    // Sequencing state: FSM, wait counter, pending redirect, trap PC and fault pulse.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            fsm_r         <= ST_BOOT;
            cnt_r         <= 8'd0;
            pend_valid_r  <= 1'b0;
            pend_target_r <= '0;
            epc_r         <= '0;
            fetch_fault_r <= 1'b0;
        end else begin
            fetch_fault_r <= 1'b0;
            if (bus.trap_req) begin
                // A fault coinciding with a trap is one trap, but still reported.
                epc_r         <= bus.pc_value;
                pend_valid_r  <= 1'b0;
                cnt_r         <= 8'd0;
                fsm_r         <= ST_FETCH;
                fetch_fault_r <= fault_s;
            end else begin
                case (fsm_r)
                    ST_BOOT: begin
                        cnt_r <= 8'd0;
                        fsm_r <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        if (advance_s) begin
                            pend_valid_r <= 1'b0;
                        end else if (!bus.imem_ready) begin
                            cnt_r <= 8'd1;
                            fsm_r <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.imem_ready) begin
                            cnt_r <= 8'd0;
                            fsm_r <= ST_FETCH;
                            if (advance_s) begin
                                pend_valid_r <= 1'b0;
                            end
                        end else if (fault_s) begin
                            epc_r         <= bus.pc_value;
                            fetch_fault_r <= 1'b1;
                            pend_valid_r  <= 1'b0;
                            cnt_r         <= 8'd0;
                            fsm_r         <= ST_FETCH;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                            if (redirect_req_s) begin
                                pend_valid_r  <= 1'b1;
                                pend_target_r <= capture_target_s;
                            end
                        end
                    end
                    default: begin
                        fsm_r <= ST_BOOT;
                    end
                endcase
            end
        end
    end

    assign bus.epc         = epc_r;
    assign bus.fetch_fault = fetch_fault_r;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl. Stimulus pushes hand-computed expected
// outputs into a queue; a monitor on the rising edge (opposite to the DUT's
// falling active edge) pops and compares. A small PC register model closes
// the loop so pc_value follows next_pc.
module tb_pc_fetch_ctrl;
    logic clk;
    logic reset;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(
        .N        (32),
        .TRAP_VEC (32'h0040_0180),
        .TIMEOUT  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] npc;
        logic        stall;
        logic        flush;
        logic        req;
        bit          chk_reg;
        logic [31:0] epc;
        logic        ff;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model: loads next_pc on the falling edge unless stalled.
    always @(negedge clk or negedge reset) begin
        if (!reset) bus.pc_value <= 32'h0040_0000;
        else if (!bus.pc_stall) bus.pc_value <= bus.next_pc;
    end

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: actual %h required %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle.
    always @(posedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "next_pc",  bus.next_pc, e.npc);
            cmp(e.name, "pc_stall", {31'd0, bus.pc_stall}, {31'd0, e.stall});
            cmp(e.name, "flush_if", {31'd0, bus.flush_if}, {31'd0, e.flush});
            cmp(e.name, "imem_req", {31'd0, bus.imem_req}, {31'd0, e.req});
            if (e.chk_reg) begin
                cmp(e.name, "epc",         bus.epc, e.epc);
                cmp(e.name, "fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, e.ff});
            end
        end
    end

    task automatic drive(input logic rdy, input logic hz, input logic jp, input logic [31:0] jt,
                         input logic br, input logic [31:0] bt, input logic tr);
        bus.imem_ready      = rdy;
        bus.load_use_hazard = hz;
        bus.jump            = jp;
        bus.jump_target     = jt;
        bus.branch_taken    = br;
        bus.branch_target   = bt;
        bus.trap_req        = tr;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic expect_cyc(input string nm, input logic [31:0] npc, input logic st, input logic fl,
                              input logic rq, input bit chk, input logic [31:0] ep, input logic ff);
        exp_t e;
        e.name = nm; e.npc = npc; e.stall = st; e.flush = fl; e.req = rq;
        e.chk_reg = chk; e.epc = ep; e.ff = ff;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        @(negedge clk);
        #1;
        // Reset and boot
        expect_cyc("rst",   32'h0040_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        reset = 1'b1;
        expect_cyc("boot",  32'h0040_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        expect_cyc("seq1",  32'h0040_0004, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        expect_cyc("seq2",  32'h0040_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        // Load-use hazard holds, a jump breaks through it
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        expect_cyc("hz1",   32'h0040_0008, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        expect_cyc("hz2",   32'h0040_0008, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h0040_0011, 1'b0, 32'd0, 1'b0);
        expect_cyc("hzjmp", 32'h0040_0010, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        // Jump beats branch, target aligned
        drive(1'b1, 1'b0, 1'b1, 32'h0040_0103, 1'b1, 32'h0040_0200, 1'b0);
        expect_cyc("jb",    32'h0040_0100, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        idle();
        expect_cyc("seq3",  32'h0040_0104, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        // Not ready for 3 cycles, branch captured in 2nd WAIT cycle
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        expect_cyc("nrdy",  32'h0040_0104, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        expect_cyc("wait1", 32'h0040_0104, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0042, 1'b0);
        expect_cyc("wait2", 32'h0040_0104, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        idle();
        expect_cyc("pend",  32'h0040_0040, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        expect_cyc("seq4",  32'h0040_0044, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        // Fetch timeout at 0x0040_0020
        drive(1'b1, 1'b0, 1'b1, 32'h0040_0020, 1'b0, 32'd0, 1'b0);
        expect_cyc("j20",   32'h0040_0020, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        expect_cyc("to_f",  32'h0040_0020, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            expect_cyc("to_w", 32'h0040_0020, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        end
        expect_cyc("fault", 32'h0040_0180, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        idle();
        expect_cyc("post_f", 32'h0040_0184, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0020, 1'b1);
        expect_cyc("ff_end", 32'h0040_0188, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0020, 1'b0);
        // Trap during WAIT at 0x0040_0030 clears a pending jump
        drive(1'b1, 1'b0, 1'b1, 32'h0040_0030, 1'b0, 32'd0, 1'b0);
        expect_cyc("j30",   32'h0040_0030, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        expect_cyc("tw_f",  32'h0040_0030, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h0040_0300, 1'b0, 32'd0, 1'b0);
        expect_cyc("tw_w1", 32'h0040_0030, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        expect_cyc("trap",  32'h0040_0180, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        idle();
        expect_cyc("post_t", 32'h0040_0184, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0030, 1'b0);
        // Reset mid-WAIT discards a captured branch
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        expect_cyc("rw_f",  32'h0040_0184, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0500, 1'b0);
        expect_cyc("rw_w1", 32'h0040_0184, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        reset = 1'b0;
        idle();
        expect_cyc("rst_mid", 32'h0040_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        reset = 1'b1;
        expect_cyc("boot2", 32'h0040_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        expect_cyc("seq5",  32'h0040_0004, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        // PC+4 wraps at the top of the address space
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
        expect_cyc("jmax",  32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        idle();
        expect_cyc("wrap",  32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        cmp("end", "queue_left", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
